// File: rtl/risc_pkg.sv
// Shared definitions for the RiSC-16 decode stage: widths, opcodes,
// instruction field positions and the ID/EX pipeline register layout.
package risc_pkg;

  localparam int WORD_LEN     = 16;
  localparam int REG_ADDR_LEN = 3;

  // Instruction field bit positions
  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 13;
  localparam int RA_MSB    = 12;
  localparam int RA_LSB    = 10;
  localparam int RB_MSB    = 9;
  localparam int RB_LSB    = 7;
  localparam int RC_MSB    = 2;
  localparam int RC_LSB    = 0;
  localparam int IMM7_MSB  = 6;
  localparam int IMM10_MSB = 9;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_ADDI = 3'd1,
    OP_NAND = 3'd2,
    OP_LUI  = 3'd3,
    OP_SW   = 3'd4,
    OP_LW   = 3'd5,
    OP_BEQ  = 3'd6,
    OP_JALR = 3'd7
  } opcode_t;

  typedef struct packed {
    logic                    vld;
    opcode_t                 op;
    logic [REG_ADDR_LEN-1:0] tgt;
    logic                    wr_en;
    logic [WORD_LEN-1:0]     op1;
    logic [WORD_LEN-1:0]     op2;
    logic [WORD_LEN-1:0]     imm;
    logic [WORD_LEN-1:0]     pc;
  } idex_t;

  function automatic logic [WORD_LEN-1:0] sext_imm7(input logic [IMM7_MSB:0] imm7);
    return {{(WORD_LEN-IMM7_MSB-1){imm7[IMM7_MSB]}}, imm7};
  endfunction

endpackage

// File: rtl/risc_decoder.sv
// Combinational RiSC-16 instruction decoder: register sources, destination,
// source-usage flags, write flag and the formatted immediate.
module risc_decoder
  import risc_pkg::*;
(
  input  logic [WORD_LEN-1:0]     instr,
  output logic [REG_ADDR_LEN-1:0] src1,
  output logic [REG_ADDR_LEN-1:0] src2,
  output logic [REG_ADDR_LEN-1:0] tgt,
  output logic                    uses_src1,
  output logic                    uses_src2,
  output logic                    writes,
  output logic [WORD_LEN-1:0]     imm
);

  opcode_t op;

  assign op = opcode_t'(instr[OP_MSB:OP_LSB]);

  // Field extraction and per-opcode source/destination selection
  always_comb begin
    src1      = instr[RB_MSB:RB_LSB];
    src2      = '0;
    tgt       = instr[RA_MSB:RA_LSB];
    uses_src1 = 1'b1;
    uses_src2 = 1'b0;
    writes    = 1'b0;
    imm       = sext_imm7(instr[IMM7_MSB:0]);
    case (op)
      OP_ADD, OP_NAND: begin
        src2      = instr[RC_MSB:RC_LSB];
        uses_src2 = 1'b1;
        writes    = 1'b1;
      end
      OP_ADDI, OP_LW, OP_JALR: begin
        writes = 1'b1;
      end
      OP_LUI: begin
        uses_src1 = 1'b0;
        writes    = 1'b1;
        imm       = {instr[IMM10_MSB:0], {(WORD_LEN-IMM10_MSB-1){1'b0}}};
      end
      OP_SW, OP_BEQ: begin
        src2      = instr[RA_MSB:RA_LSB];
        uses_src2 = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/risc_id_stage.sv
// RiSC-16 decode stage: IF/ID register, register-file read addressing,
// writeback bypass, load-use hazard detection and the ID/EX register.
module risc_id_stage
  import risc_pkg::*;
#(
  parameter int p_WORD_LEN     = 16,
  parameter int p_REG_ADDR_LEN = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_if_valid,
  input  logic [p_WORD_LEN-1:0]     i_if_instr,
  input  logic [p_WORD_LEN-1:0]     i_if_pc,
  output logic                      o_if_stall,
  input  logic                      i_flush,
  input  logic                      i_ex_stall,
  output logic [p_REG_ADDR_LEN-1:0] o_rf_src1,
  output logic [p_REG_ADDR_LEN-1:0] o_rf_src2,
  input  logic [p_WORD_LEN-1:0]     i_rf_src1_data,
  input  logic [p_WORD_LEN-1:0]     i_rf_src2_data,
  input  logic                      i_wb_wr_en,
  input  logic [p_REG_ADDR_LEN-1:0] i_wb_tgt,
  input  logic [p_WORD_LEN-1:0]     i_wb_data,
  output logic                      o_ex_valid,
  output logic [2:0]                o_ex_op,
  output logic [p_REG_ADDR_LEN-1:0] o_ex_tgt,
  output logic                      o_ex_wr_en,
  output logic [p_WORD_LEN-1:0]     o_ex_op1,
  output logic [p_WORD_LEN-1:0]     o_ex_op2,
  output logic [p_WORD_LEN-1:0]     o_ex_imm,
  output logic [p_WORD_LEN-1:0]     o_ex_pc
);

  logic                    ifid_vld_p0;
  logic [WORD_LEN-1:0]     ifid_instr_p0;
  logic [WORD_LEN-1:0]     ifid_pc_p0;
  idex_t                   dec_p0;
  idex_t                   idex_p1;
  opcode_t                 ifid_op;
  logic [REG_ADDR_LEN-1:0] src1;
  logic [REG_ADDR_LEN-1:0] src2;
  logic [REG_ADDR_LEN-1:0] tgt;
  logic                    uses_src1;
  logic                    uses_src2;
  logic                    writes;
  logic [WORD_LEN-1:0]     imm;
  logic                    hazard;

  // r0 reads as zero; otherwise a same-cycle writeback wins over the RF,
  // since the RF only updates on the next edge.
  function automatic logic [WORD_LEN-1:0] sel_operand(
    input logic [REG_ADDR_LEN-1:0] src,
    input logic [WORD_LEN-1:0]     rf_data,
    input logic                    wb_en,
    input logic [REG_ADDR_LEN-1:0] wb_tgt,
    input logic [WORD_LEN-1:0]     wb_data
  );
    if (src == '0) return '0;
    else if (wb_en && (wb_tgt == src)) return wb_data;
    else return rf_data;
  endfunction

  assign ifid_op = opcode_t'(ifid_instr_p0[OP_MSB:OP_LSB]);

  risc_decoder u_decoder (
    .instr     (ifid_instr_p0),
    .src1      (src1),
    .src2      (src2),
    .tgt       (tgt),
    .uses_src1 (uses_src1),
    .uses_src2 (uses_src2),
    .writes    (writes),
    .imm       (imm)
  );

  assign o_rf_src1 = src1;
  assign o_rf_src2 = src2;

  // A load in ID/EX whose result is read by the instruction in IF/ID
  assign hazard = ifid_vld_p0 && idex_p1.vld && (idex_p1.op == OP_LW) &&
                  (idex_p1.tgt != '0) &&
                  ((uses_src1 && (src1 == idex_p1.tgt)) ||
                   (uses_src2 && (src2 == idex_p1.tgt)));

  assign o_if_stall = !i_flush && (i_ex_stall || hazard);

  // Decoded ID/EX candidate; an empty IF/ID slot becomes an all-zero bubble
  always_comb begin
    dec_p0 = '0;
    if (ifid_vld_p0) begin
      dec_p0.vld   = 1'b1;
      dec_p0.op    = ifid_op;
      dec_p0.tgt   = tgt;
      dec_p0.wr_en = writes && (tgt != '0);
      dec_p0.op1   = sel_operand(src1, i_rf_src1_data, i_wb_wr_en, i_wb_tgt, i_wb_data);
      dec_p0.op2   = sel_operand(src2, i_rf_src2_data, i_wb_wr_en, i_wb_tgt, i_wb_data);
      dec_p0.imm   = imm;
      dec_p0.pc    = ifid_pc_p0;
    end
  end

  // Pipeline register update: flush > downstream stall > hazard bubble > advance
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ifid_vld_p0   <= 1'b0;
      ifid_instr_p0 <= '0;
      ifid_pc_p0    <= '0;
      idex_p1       <= '0;
    end else if (i_flush) begin
      ifid_vld_p0   <= 1'b0;
      idex_p1.vld   <= 1'b0;
      idex_p1.wr_en <= 1'b0;
    end else if (i_ex_stall) begin
      ifid_vld_p0   <= ifid_vld_p0;
    end else if (hazard) begin
      idex_p1       <= '0;
    end else begin
      ifid_vld_p0   <= i_if_valid;
      ifid_instr_p0 <= i_if_instr;
      ifid_pc_p0    <= i_if_pc;
      idex_p1       <= dec_p0;
    end
  end

  assign o_ex_valid = idex_p1.vld;
  assign o_ex_op    = idex_p1.op;
  assign o_ex_tgt   = idex_p1.tgt;
  assign o_ex_wr_en = idex_p1.wr_en;
  assign o_ex_op1   = idex_p1.op1;
  assign o_ex_op2   = idex_p1.op2;
  assign o_ex_imm   = idex_p1.imm;
  assign o_ex_pc    = idex_p1.pc;

endmodule

// File: tb/tb_risc_id_stage.sv
// Self-checking bench for risc_id_stage: directed pipeline scenarios followed
// by a randomized instruction stream checked against a transaction-level model.
module tb_risc_id_stage;

  localparam int NS = 60;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_if_valid;
  logic [15:0] i_if_instr;
  logic [15:0] i_if_pc;
  logic        o_if_stall;
  logic        i_flush;
  logic        i_ex_stall;
  logic [2:0]  o_rf_src1;
  logic [2:0]  o_rf_src2;
  logic [15:0] i_rf_src1_data;
  logic [15:0] i_rf_src2_data;
  logic        i_wb_wr_en;
  logic [2:0]  i_wb_tgt;
  logic [15:0] i_wb_data;
  logic        o_ex_valid;
  logic [2:0]  o_ex_op;
  logic [2:0]  o_ex_tgt;
  logic        o_ex_wr_en;
  logic [15:0] o_ex_op1;
  logic [15:0] o_ex_op2;
  logic [15:0] o_ex_imm;
  logic [15:0] o_ex_pc;

  logic [15:0] rf [8];
  logic        wbe;
  logic [2:0]  wbt;
  logic [15:0] wbd;

  int checks   = 0;
  int failures = 0;

  logic        s_vld [NS];
  logic [15:0] s_ins [NS];
  logic [15:0] s_pc  [NS];
  logic [71:0] exp_q [$];
  int          nvalid, exp_hz, got, stalls, k;
  logic [2:0]  r_op, r_ra, r_rb, r_rc, p_op, p_ra, c_s2;
  logic [3:0]  r_mid;
  logic        p_vld;

  wire [71:0] ex_bus = {o_ex_valid, o_ex_op, o_ex_tgt, o_ex_wr_en,
                        o_ex_op1, o_ex_op2, o_ex_imm, o_ex_pc};

  always #5 clk = ~clk;

  assign i_rf_src1_data = rf[o_rf_src1];
  assign i_rf_src2_data = rf[o_rf_src2];

  risc_id_stage dut (
    .i_clk          (clk),
    .i_rst_n        (i_rst_n),
    .i_if_valid     (i_if_valid),
    .i_if_instr     (i_if_instr),
    .i_if_pc        (i_if_pc),
    .o_if_stall     (o_if_stall),
    .i_flush        (i_flush),
    .i_ex_stall     (i_ex_stall),
    .o_rf_src1      (o_rf_src1),
    .o_rf_src2      (o_rf_src2),
    .i_rf_src1_data (i_rf_src1_data),
    .i_rf_src2_data (i_rf_src2_data),
    .i_wb_wr_en     (i_wb_wr_en),
    .i_wb_tgt       (i_wb_tgt),
    .i_wb_data      (i_wb_data),
    .o_ex_valid     (o_ex_valid),
    .o_ex_op        (o_ex_op),
    .o_ex_tgt       (o_ex_tgt),
    .o_ex_wr_en     (o_ex_wr_en),
    .o_ex_op1       (o_ex_op1),
    .o_ex_op2       (o_ex_op2),
    .o_ex_imm       (o_ex_imm),
    .o_ex_pc        (o_ex_pc)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc);
    i_if_valid = v;
    i_if_instr = ins;
    i_if_pc    = pc;
  endtask

  function automatic logic [71:0] pk(input logic v, input logic [2:0] op, input logic [2:0] tgt,
                                     input logic we, input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] imm, input logic [15:0] pc);
    return {v, op, tgt, we, a, b, imm, pc};
  endfunction

  // Architectural operand value seen by an instruction under a constant writeback
  function automatic logic [15:0] rval(input logic [2:0] r);
    if (r == 3'd0) return 16'h0;
    if (wbe && (wbt == r)) return wbd;
    return rf[r];
  endfunction

  function automatic logic [2:0] second_src(input logic [15:0] ins);
    logic [2:0] op;
    op = ins[15:13];
    if (op == 3'd0 || op == 3'd2) return ins[2:0];
    if (op == 3'd4 || op == 3'd6) return ins[12:10];
    return 3'd0;
  endfunction

  function automatic logic [71:0] exp_dec(input logic [15:0] ins, input logic [15:0] pc);
    logic [2:0]  op, ra;
    logic        wr;
    logic [15:0] imm;
    op  = ins[15:13];
    ra  = ins[12:10];
    wr  = !(op == 3'd4 || op == 3'd6);
    imm = (op == 3'd3) ? {ins[9:0], 6'b0} : {{9{ins[6]}}, ins[6:0]};
    return pk(1'b1, op, ra, wr && (ra != 3'd0), rval(ins[9:7]), rval(second_src(ins)), imm, pc);
  endfunction

  initial begin
    i_rst_n = 1'b0; i_flush = 1'b0; i_ex_stall = 1'b0;
    i_wb_wr_en = 1'b0; i_wb_tgt = 3'd0; i_wb_data = 16'h0;
    wbe = 1'b0; wbt = 3'd0; wbd = 16'h0;
    drive(1'b0, 16'h0, 16'h0);
    rf[0] = 16'hDEAD; rf[1] = 16'h0000; rf[2] = 16'h0005; rf[3] = 16'h0007;
    rf[4] = 16'h0444; rf[5] = 16'h0555; rf[6] = 16'h0666; rf[7] = 16'h0777;
    repeat (2) @(negedge clk);
    check("reset_ex", ex_bus, 72'(0));
    check("reset_stall", 72'(o_if_stall), 72'(0));
    i_rst_n = 1'b1;

    // ADD r1,r2,r3
    drive(1'b1, 16'h0503, 16'h0010); @(negedge clk);
    drive(1'b0, 16'h0, 16'h0);
    check("t1_src1", 72'(o_rf_src1), 72'(2));
    check("t1_src2", 72'(o_rf_src2), 72'(3));
    @(negedge clk);
    check("t1_add", ex_bus, pk(1'b1, 3'd0, 3'd1, 1'b1, 16'd5, 16'd7, 16'h0003, 16'h0010));

    // LW r2,r0,4 then dependent ADD r3,r2,r2
    drive(1'b1, 16'hA804, 16'h0020); @(negedge clk);
    drive(1'b1, 16'h0D02, 16'h0021);
    #1 check("t2_nostall_pre", 72'(o_if_stall), 72'(0));
    @(negedge clk);
    check("t2_lw", ex_bus, pk(1'b1, 3'd5, 3'd2, 1'b1, 16'h0, 16'h0, 16'h0004, 16'h0020));
    #1 check("t2_stall", 72'(o_if_stall), 72'(1));
    @(negedge clk);
    check("t2_bubble", 72'({o_ex_valid, o_ex_wr_en}), 72'(0));
    check("t2_stall_end", 72'(o_if_stall), 72'(0));
    drive(1'b0, 16'h0, 16'h0); @(negedge clk);
    check("t2_add", ex_bus, pk(1'b1, 3'd0, 3'd3, 1'b1, 16'd5, 16'd5, 16'h0002, 16'h0021));

    // ADDI r1,r1,-1 with same-cycle writeback to r1
    drive(1'b1, 16'h24FF, 16'h0030); @(negedge clk);
    drive(1'b0, 16'h0, 16'h0);
    i_wb_wr_en = 1'b1; i_wb_tgt = 3'd1; i_wb_data = 16'h1234;
    @(negedge clk);
    i_wb_wr_en = 1'b0;
    check("t3_bypass", ex_bus, pk(1'b1, 3'd1, 3'd1, 1'b1, 16'h1234, 16'h0, 16'hFFFF, 16'h0030));

    // LW r7 then LUI r4,0x3FF (rB field is r7, but LUI reads nothing), then ADD r0
    rf[1] = 16'h00AA;
    drive(1'b1, 16'hBC00, 16'h0040); @(negedge clk);
    drive(1'b1, 16'h73FF, 16'h0041); @(negedge clk);
    check("t4_lui_src2", 72'(o_rf_src2), 72'(0));
    drive(1'b1, 16'h0081, 16'h0042);
    #1 check("t4_lui_nohazard", 72'(o_if_stall), 72'(0));
    @(negedge clk);
    check("t4_lui", ex_bus, pk(1'b1, 3'd3, 3'd4, 1'b1, rf[7], 16'h0, 16'hFFC0, 16'h0041));
    drive(1'b0, 16'h0, 16'h0); @(negedge clk);
    check("t4_add_r0", ex_bus, pk(1'b1, 3'd0, 3'd0, 1'b0, 16'h00AA, 16'h00AA, 16'h0001, 16'h0042));

    // Flush with both registers full and a concurrent downstream stall
    drive(1'b1, 16'h0503, 16'h0050); @(negedge clk);
    drive(1'b1, 16'h24FF, 16'h0051); @(negedge clk);
    check("t5_pre", 72'(o_ex_valid), 72'(1));
    i_flush = 1'b1; i_ex_stall = 1'b1;
    #1 check("t5_stall_flush", 72'(o_if_stall), 72'(0));
    @(negedge clk);
    check("t5_flush_ex", 72'({o_ex_valid, o_ex_wr_en}), 72'(0));
    check("t5_stall_flush2", 72'(o_if_stall), 72'(0));
    i_flush = 1'b0; i_ex_stall = 1'b0;
    drive(1'b0, 16'h0, 16'h0); @(negedge clk);
    check("t5_ifid_killed", 72'({o_ex_valid, o_ex_wr_en}), 72'(0));

    // Downstream stall for 3 cycles, then asynchronous reset mid-stall
    drive(1'b1, 16'h0503, 16'h0060); @(negedge clk);
    drive(1'b1, 16'h24FF, 16'h0061); @(negedge clk);
    i_ex_stall = 1'b1;
    drive(1'b1, 16'h0D02, 16'h0062);
    for (int i = 0; i < 3; i++) begin
      #1 check("t6_stall", 72'(o_if_stall), 72'(1));
      @(negedge clk);
      check("t6_frozen_ex", ex_bus, pk(1'b1, 3'd0, 3'd1, 1'b1, 16'd5, 16'd7, 16'h0003, 16'h0060));
      check("t6_frozen_ifid", 72'(o_rf_src1), 72'(1));
    end
    #2 i_rst_n = 1'b0;
    #1 check("t6_reset_ex", ex_bus, 72'(0));
    @(negedge clk);
    i_ex_stall = 1'b0; i_rst_n = 1'b1;
    drive(1'b0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    check("t6_no_stale", 72'({o_ex_valid, o_ex_wr_en}), 72'(0));

    // Randomized stream with fixed RF contents and a constant writeback
    for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
    rf[0] = rf[0] | 16'h0001;
    wbe = 1'($urandom_range(0, 1));
    wbt = 3'($urandom_range(0, 7));
    wbd = 16'($urandom);
    i_wb_wr_en = wbe; i_wb_tgt = wbt; i_wb_data = wbd;
    nvalid = 0; exp_hz = 0; p_vld = 1'b0; p_op = 3'd0; p_ra = 3'd0;
    for (int i = 0; i < NS; i++) begin
      r_op  = ($urandom_range(0, 3) == 0) ? 3'd5 : 3'($urandom_range(0, 7));
      r_ra  = 3'($urandom_range(0, 3));
      r_rb  = 3'($urandom_range(0, 3));
      r_rc  = 3'($urandom_range(0, 3));
      r_mid = 4'($urandom);
      s_vld[i] = ($urandom_range(0, 4) != 0);
      s_ins[i] = {r_op, r_ra, r_rb, r_mid, r_rc};
      s_pc[i]  = 16'($urandom);
      if (s_vld[i]) begin
        exp_q.push_back(exp_dec(s_ins[i], s_pc[i]));
        nvalid++;
        c_s2 = second_src(s_ins[i]);
        if (p_vld && p_op == 3'd5 && p_ra != 3'd0 &&
            ((r_op != 3'd3 && r_rb == p_ra) ||
             ((r_op == 3'd0 || r_op == 3'd2 || r_op == 3'd4 || r_op == 3'd6) && c_s2 == p_ra)))
          exp_hz++;
      end
      p_vld = s_vld[i]; p_op = r_op; p_ra = r_ra;
    end
    k = 0; got = 0; stalls = 0;
    for (int c = 0; c < 400 && got < nvalid; c++) begin
      @(negedge clk);
      if (o_ex_valid) begin
        if (exp_q.size() == 0) check("rnd_extra", ex_bus, 72'(0));
        else begin
          check("rnd_issue", ex_bus, exp_q.pop_front());
          got++;
        end
      end else begin
        check("rnd_bubble", 72'({o_ex_valid, o_ex_wr_en}), 72'(0));
      end
      if (k < NS) drive(s_vld[k], s_ins[k], s_pc[k]);
      else drive(1'b0, 16'h0, 16'h0);
      #1;
      if (o_if_stall) stalls++;
      else if (k < NS) k++;
    end
    check("rnd_count", 72'(got), 72'(nvalid));
    check("rnd_hazards", 72'(stalls), 72'(exp_hz));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
